// File: rtl/flash_qspi_reader.sv
// flash_qspi_reader: Quad Output Fast Read (0x6B) sequencer for a QSPI flash on DDR SB_IO pads, bytes returned via a 4-entry FIFO
// Ports: CLK/RST (sync, active-high); req/addr/len start a burst, busy/done report progress;
//   rd_data/rd_valid/rd_ready are the FIFO read side; FLASH_CSb, flash_clk_ddr, flash_out_dN_ddr and
//   flash_pin_dir drive the pads (all registered); flash_in_dN_ddr[0] returns read nibbles RD_LAT cycles after their SCK.
// Define FLASH_WAKEUP_EN to send Release Power-Down (0xAB) and wait out tRES1 after reset before accepting requests.
module flash_qspi_reader #(
  parameter int DUMMY_CYCLES = 8,
  parameter int RD_LAT       = 2,
  parameter int CS_IDLE      = 4,
  parameter int LEN_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             FLASH_CSb,
  output logic [1:0]       flash_clk_ddr,
  output logic [1:0]       flash_out_d0_ddr,
  output logic [1:0]       flash_out_d1_ddr,
  output logic [1:0]       flash_out_d2_ddr,
  output logic [1:0]       flash_out_d3_ddr,
  input  logic [1:0]       flash_in_d0_ddr,
  input  logic [1:0]       flash_in_d1_ddr,
  input  logic [1:0]       flash_in_d2_ddr,
  input  logic [1:0]       flash_in_d3_ddr,
  output logic [3:0]       flash_pin_dir
);
  typedef enum logic [3:0] {IDLE, CMD, ADDR, DUMMY, DATA, DRAIN, CS_GAP, WAKE, WAKE_GAP} state_t;
`ifdef FLASH_WAKEUP_EN
  localparam state_t RST_ST = WAKE;
`else
  localparam state_t RST_ST = IDLE;
`endif
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic ph_q, ph_d, hi_q, done_q, done_d;
  logic [3:0] nib_q, din;
  logic [2:0] inflight_q, fcnt_q;
  logic [RD_LAT:0] tag_q;
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic csb_q, csb_d, sck_q, sck_d, d0_q, d0_d;
  logic [3:0] dir_q, dir_d;
  logic issue, cap, push, pop, free_ok, unused_in;
  assign din = {flash_in_d3_ddr[0], flash_in_d2_ddr[0], flash_in_d1_ddr[0], flash_in_d0_ddr[0]};
  assign unused_in = ^{flash_in_d3_ddr[1], flash_in_d2_ddr[1], flash_in_d1_ddr[1], flash_in_d0_ddr[1]};
  // a nibble is on the input pads while its tag sits in the last stage; every second one completes a byte
  assign cap = tag_q[RD_LAT];
  assign push = cap && hi_q;
  assign pop = rd_valid && rd_ready;
  // a byte is only started when the FIFO can absorb it plus everything already on its way
  assign free_ok = (3'd4 - fcnt_q) > inflight_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 6'd1;
    sh_d = sh_q;
    rem_d = rem_q;
    ph_d = ph_q;
    csb_d = 1'b0;
    sck_d = 1'b0;
    d0_d = 1'b0;
    dir_d = 4'b0000;
    done_d = 1'b0;
    issue = 1'b0;
    case (state_q)
      IDLE: begin
        csb_d = 1'b1;
        cnt_d = '0;
        if (req) begin
          done_d = len == '0;
          state_d = len == '0 ? CS_GAP : CMD;
          sh_d = {8'h6B, addr};
          rem_d = len;
        end
      end
      WAKE, CMD, ADDR: begin
        sck_d = 1'b1;
        d0_d = sh_q[31];
        dir_d = 4'b0001;
        sh_d = {sh_q[30:0], 1'b0};
        if (cnt_q == (state_q == ADDR ? 6'd23 : 6'd7)) begin
          cnt_d = '0;
          state_d = state_q == WAKE ? WAKE_GAP : state_q == CMD ? ADDR : DUMMY;
        end
      end
      WAKE_GAP: begin
        csb_d = 1'b1;
        if (cnt_q == 6'd48) state_d = IDLE;
      end
      DUMMY: begin
        sck_d = 1'b1;
        if (cnt_q == 6'(DUMMY_CYCLES - 1)) state_d = DATA;
      end
      DATA: begin
        if (ph_q) begin
          sck_d = 1'b1;
          ph_d = 1'b0;
          if (rem_q == '0) state_d = DRAIN;
        end else if (free_ok) begin
          sck_d = 1'b1;
          ph_d = 1'b1;
          issue = 1'b1;
          rem_d = rem_q - 1'b1;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          csb_d = 1'b1;
          done_d = 1'b1;
          cnt_d = '0;
          state_d = CS_GAP;
        end
      end
      CS_GAP: begin
        csb_d = 1'b1;
        if (cnt_q == 6'(CS_IDLE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RST_ST;
      cnt_q <= '0;
      sh_q <= {8'hAB, 24'h0};
      rem_q <= '0;
      ph_q <= 1'b0;
      hi_q <= 1'b0;
      nib_q <= '0;
      inflight_q <= '0;
      tag_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      fcnt_q <= '0;
      csb_q <= 1'b1;
      sck_q <= 1'b0;
      d0_q <= 1'b0;
      dir_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rem_q <= rem_d;
      ph_q <= ph_d;
      hi_q <= cap ? !hi_q : hi_q;
      nib_q <= cap && !hi_q ? din : nib_q;
      inflight_q <= inflight_q + 3'(issue) - 3'(push);
      tag_q <= {tag_q[RD_LAT-1:0], state_q == DATA && sck_d};
      wp_q <= wp_q + 2'(push);
      rp_q <= rp_q + 2'(pop);
      fcnt_q <= fcnt_q + 3'(push) - 3'(pop);
      csb_q <= csb_d;
      sck_q <= sck_d;
      d0_q <= d0_d;
      dir_q <= dir_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge CLK) if (push) mem_q[wp_q] <= {nib_q, din};
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign rd_data = mem_q[rp_q];
  assign rd_valid = fcnt_q != '0;
  assign FLASH_CSb = csb_q;
  assign flash_clk_ddr = {sck_q, 1'b0};
  assign flash_out_d0_ddr = {2{d0_q}};
  assign flash_out_d1_ddr = 2'b00;
  assign flash_out_d2_ddr = 2'b00;
  assign flash_out_d3_ddr = 2'b00;
  assign flash_pin_dir = dir_q;
endmodule

// File: tb/tb_flash_qspi_reader.sv
// tb_flash_qspi_reader: flash/pad model plus scoreboard bench for flash_qspi_reader
module tb_flash_qspi_reader;
  localparam int RD_LAT = 2;
  localparam int CS_IDLE = 4;
  logic CLK = 1'b0, RST = 1'b1, req = 1'b0, rd_ready = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic busy, done, rd_valid, FLASH_CSb;
  logic [7:0] rd_data;
  logic [1:0] flash_clk_ddr, out_d0, out_d1, out_d2, out_d3;
  logic [1:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
  logic [3:0] flash_pin_dir;
  flash_qspi_reader dut (
    .CLK(CLK), .RST(RST), .req(req), .addr(addr), .len(len), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .FLASH_CSb(FLASH_CSb),
    .flash_clk_ddr(flash_clk_ddr), .flash_out_d0_ddr(out_d0), .flash_out_d1_ddr(out_d1),
    .flash_out_d2_ddr(out_d2), .flash_out_d3_ddr(out_d3), .flash_in_d0_ddr(in_d0),
    .flash_in_d1_ddr(in_d1), .flash_in_d2_ddr(in_d2), .flash_in_d3_ddr(in_d3),
    .flash_pin_dir(flash_pin_dir)
  );
  always #5 CLK = ~CLK;
  int errs = 0, checks = 0, pops = 0, dones = 0, trans = 0, nibs = 0, csb_low = 0;
  logic [7:0] exp_q [$];
  logic [31:0] cmd_q [$];
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  // flash model: shifts in command/address on SCK rises, answers with quad data delayed RD_LAT cycles by the pad pipe
  int e = 0;
  logic [31:0] rx = '0;
  logic [23:0] fa;
  logic [7:0] fb;
  logic [3:0] n;
  logic [3:0] dl [0:RD_LAT];
  logic prev_csb = 1'b1;
  initial for (int k = 0; k <= RD_LAT; k++) dl[k] = '0;
  always @(negedge CLK) begin
    n = '0;
    if (!FLASH_CSb && prev_csb) trans++;
    prev_csb = FLASH_CSb;
    if (!FLASH_CSb) csb_low++;
    if (FLASH_CSb) e = 0;
    else if (flash_clk_ddr == 2'b10) begin
      chk("pin_dir", {28'h0, flash_pin_dir}, e < 32 ? 32'h1 : 32'h0);
      if (e < 32) rx = e == 0 ? {31'h0, out_d0[0]} : {rx[30:0], out_d0[0]};
      if (e == 32) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_cmd: got %0h expected none", rx);
        end else chk("cmd_addr", rx, cmd_q.pop_front());
      end
      if (e >= 40) begin
        nibs++;
        fa = rx[23:0] + 24'((e - 40) / 2);
        fb = fbyte(fa);
        n = e % 2 == 0 ? fb[7:4] : fb[3:0];
      end
      e++;
    end
    for (int k = RD_LAT; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = n;
    in_d0 = {2{dl[RD_LAT][0]}};
    in_d1 = {2{dl[RD_LAT][1]}};
    in_d2 = {2{dl[RD_LAT][2]}};
    in_d3 = {2{dl[RD_LAT][3]}};
  end
  always @(negedge CLK) begin
    if (done) dones++;
    if (rd_valid && rd_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_byte: got %0h expected none", rd_data);
      end else chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
    end
  end
  task automatic start(input logic [23:0] a, input logic [15:0] l);
    addr = a;
    len = l;
    if (l != 0) cmd_q.push_back({8'h6B, a});
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask
  task automatic wait_done(input string name, input int limit);
    int k = 0, d0 = dones;
    while (dones == d0 && k < limit) begin
      k++;
      tick();
    end
    chk(name, dones != d0, 1);
  endtask
  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 100) begin
      k++;
      tick();
    end
    chk(name, busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int d0, n0, c0, t0, p0, b, dh, k, hc;
    tick(3);
    RST = 1'b0;
    chk("rst_csb", FLASH_CSb, 1);
    chk("rst_sck", flash_clk_ddr, 0);
    chk("rst_dir", flash_pin_dir, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rd_valid, 0);
`ifdef FLASH_WAKEUP_EN
    chk("t6_busy", busy, 1);
    t0 = trans;
    k = 0;
    while (FLASH_CSb && k < 50) begin k++; tick(); end
    while (!FLASH_CSb && k < 100) begin k++; tick(); end
    chk("t6_cmd", {24'h0, rx[7:0]}, 32'hAB);
    hc = 0;
    while (busy && hc < 200) begin
      addr = 24'h000500;
      len = 16'd1;
      req = hc == 10;
      hc++;
      tick();
    end
    req = 1'b0;
    chk("t6_gap", hc >= 48, 1);
    tick(60);
    chk("t6_no_trans", trans - t0, 1);
`else
    chk("rst_busy", busy, 0);
    tick();
    chk("rst_busy_after", busy, 0);
`endif
    rd_ready = 1'b1;
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'hE2);
    exp_q.push_back(8'hED);
    d0 = dones;
    start(24'h012345, 16'd4);
    wait_done("t1_done_timeout", 300);
    wait_idle("t1_busy_timeout");
    chk("t1_done_count", dones - d0, 1);
    chk("t1_bytes_left", exp_q.size(), 0);
    chk("t1_cmd_left", cmd_q.size(), 0);
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(fbyte(24'h000100 + 24'(i)));
    n0 = nibs;
    start(24'h000100, 16'd16);
    tick(80);
    chk("t2_stall_nibbles", nibs - n0, 8);
    chk("t2_stall_csb", FLASH_CSb, 0);
    chk("t2_stall_sck", flash_clk_ddr, 0);
    chk("t2_stall_valid", rd_valid, 1);
    rd_ready = 1'b1;
    wait_done("t2_done_timeout", 500);
    wait_idle("t2_busy_timeout");
    chk("t2_all_nibbles", nibs - n0, 32);
    chk("t2_bytes_left", exp_q.size(), 0);
    d0 = dones;
    c0 = csb_low;
    start(24'h000400, 16'd0);
    chk("t3_done_first", done, 1);
    b = 0;
    dh = 0;
    while (busy && b < 20) begin
      if (done) dh++;
      b++;
      tick();
    end
    chk("t3_busy_cycles", b, CS_IDLE + 1);
    chk("t3_done_cycles", dh, 1);
    chk("t3_no_csb", csb_low - c0, 0);
    chk("t3_done_count", dones - d0, 1);
    for (int i = 0; i < 8; i++) exp_q.push_back(fbyte(24'h000200 + 24'(i)));
    p0 = pops;
    start(24'h000200, 16'd8);
    k = 0;
    while (pops - p0 < 2 && k < 300) begin k++; tick(); end
    chk("t4_pop_timeout", pops - p0 >= 2, 1);
    d0 = dones;
    RST = 1'b1;
    tick();
    chk("t4_csb", FLASH_CSb, 1);
    chk("t4_dir", flash_pin_dir, 0);
    chk("t4_valid", rd_valid, 0);
    chk("t4_sck", flash_clk_ddr, 0);
    RST = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    tick(20);
    chk("t4_no_done", dones - d0, 0);
    exp_q.push_back(8'hA5);
    start(24'h000000, 16'd1);
    wait_done("t4_new_timeout", 300);
    wait_idle("t4_busy_timeout");
    chk("t4_bytes_left", exp_q.size(), 0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA4);
    t0 = trans;
    start(24'h000300, 16'd2);
    tick(14);
    addr = 24'hFFFFFF;
    len = 16'd5;
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done("t5_done_timeout", 300);
    wait_idle("t5_busy_timeout");
    tick(40);
    chk("t5_trans", trans - t0, 1);
    chk("t5_bytes_left", exp_q.size(), 0);
    chk("t5_cmd_left", cmd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
